// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32 pipeline memory stage.
package riscv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_t;

endpackage

// File: rtl/dmem_access_fsm.sv
// Single-outstanding data-memory handshake: state, bounded wait counter,
// and the combinational request/stall/abort outputs.
module dmem_access_fsm
  import riscv_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mem_op,
  input  logic i_ready,
  output logic o_req,
  output logic o_stall,
  output logic o_err
);

  localparam int CW = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(DMEM_TIMEOUT - 1);

  mem_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_req       = 1'b0;
    o_stall     = 1'b0;
    o_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mem_op) begin
          o_req = 1'b1;
          if (!i_ready) begin
            o_stall     = 1'b1;
            w_state_nxt = WAIT;
            w_cnt_nxt   = '0;
          end
        end
      end
      WAIT: begin
        o_req = 1'b1;
        // A ready on the timeout cycle still completes the access.
        if (i_ready) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LAST_WAIT) begin
          o_err       = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          o_stall   = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32 Memory stage: EX/MEM and MEM/WB registers around the dmem handshake.
// Optional MEM_MISALIGN_TRAP_EN adds misalign_m and suppresses misaligned requests.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteE,
  input  logic        ResultSrcE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        RegWriteM,
  output logic [4:0]  RdM,
  output logic [31:0] ALUResultM,
  output logic        stall_m,
  output logic        dmem_err,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_m
`endif
);

  ex_mem_t     r_ex;
  logic        r_reg_write_w, r_result_src_w;
  logic [4:0]  r_rd_w;
  logic [31:0] r_alu_result_w, r_read_data_w, r_pc_plus4_w;

  logic w_mem_op, w_misalign, w_req_op, w_kill;
  logic w_req, w_stall, w_err;

  assign w_mem_op = r_ex.mem_write | ((r_ex.result_src == RESULT_MEM) & r_ex.reg_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & (r_ex.alu_result[1:0] != 2'b00);
  assign misalign_m = w_misalign;
  assign dmem_addr  = r_ex.alu_result;
`else
  assign w_misalign = 1'b0;
  assign dmem_addr  = {r_ex.alu_result[31:2], 2'b00};
`endif

  assign w_req_op = w_mem_op & ~w_misalign;
  assign w_kill   = w_err | w_misalign;

  dmem_access_fsm #(
    .DMEM_TIMEOUT(DMEM_TIMEOUT)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_mem_op(w_req_op),
    .i_ready (dmem_ready),
    .o_req   (w_req),
    .o_stall (w_stall),
    .o_err   (w_err)
  );

  assign dmem_req   = w_req;
  assign stall_m    = w_stall;
  assign dmem_err   = w_err;
  assign dmem_we    = r_ex.mem_write;
  assign dmem_wdata = r_ex.write_data;
  assign RegWriteM  = r_ex.reg_write;
  assign RdM        = r_ex.rd;
  assign ALUResultM = r_ex.alu_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (!w_stall) begin
      r_ex <= '{reg_write: RegWriteE, result_src: ResultSrcE, mem_write: MemWriteE,
                alu_result: ALUResultE, write_data: WriteDataE, pc_plus4: PCPlus4E,
                rd: RdE};
    end
  end

  // While stalled, W receives a bubble: control cleared, datapath held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 1'b0;
      r_rd_w         <= '0;
      r_alu_result_w <= '0;
      r_read_data_w  <= '0;
      r_pc_plus4_w   <= '0;
    end else if (w_stall) begin
      r_reg_write_w  <= 1'b0;
      r_result_src_w <= 1'b0;
    end else begin
      r_reg_write_w  <= r_ex.reg_write & ~w_kill;
      r_result_src_w <= r_ex.result_src;
      r_rd_w         <= r_ex.rd;
      r_alu_result_w <= r_ex.alu_result;
      r_read_data_w  <= dmem_rdata;
      r_pc_plus4_w   <= r_ex.pc_plus4;
    end
  end

  assign RegWriteW  = r_reg_write_w;
  assign ResultSrcW = r_result_src_w;
  assign RdW        = r_rd_w;
  assign ALUResultW = r_alu_result_w;
  assign ReadDataW  = r_read_data_w;
  assign PCPlus4W   = r_pc_plus4_w;

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage RV32 pipeline, directly downstream of the Execute stage. Holds the EX/MEM pipeline register, runs a single-outstanding request/ready handshake to data memory for `lw`/`sw`, and drives the MEM/WB register consumed by Writeback. Asserts a stall to the hazard unit while a data access is pending and aborts accesses that exceed a bounded wait.

## Interface
Parameters:
- `DMEM_TIMEOUT`, default 15: maximum wait cycles for `dmem_ready` before abort; legal range ≥ 1.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RegWriteE`, `ResultSrcE`, `MemWriteE`  in  1 each  control from Execute; `ResultSrcE` 0 = ALU result, 1 = memory data.
- `ALUResultE`, `WriteDataE`, `PCPlus4E`  in  32 each  datapath from Execute.
- `RdE`  in  5  destination register.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  byte address.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  load data; valid when `dmem_ready` = 1.
- `dmem_ready`  in  1  access complete.
- `RegWriteM`, `RdM`, `ALUResultM`  out  1/5/32  EX/MEM contents for forwarding.
- `stall_m`  out  1  freeze F/D/E this cycle.
- `dmem_err`  out  1  one-cycle pulse on timeout abort.
- `RegWriteW`, `ResultSrcW`  out  1 each.
- `RdW`  out  5.
- `ALUResultW`, `ReadDataW`, `PCPlus4W`  out  32 each.

## Operation
- EX/MEM register: loads all E-side inputs each edge unless `stall_m` = 1, in which case it holds.
- Memory operation in M: `mem_op` = `MemWriteM` | (`ResultSrcM` & `RegWriteM`). When all EX/MEM control bits are zero, the slot is a bubble.
- FSM with two states, IDLE and WAIT:
  - IDLE with `mem_op`: `dmem_req` = 1. If `dmem_ready` = 1, the access completes with zero wait and the FSM stays in IDLE. Otherwise `stall_m` = 1 and the FSM goes to WAIT with the counter cleared.
  - WAIT: `dmem_req` = 1 and `stall_m` = 1, and the counter increments each cycle.
    - If `dmem_ready` = 1, the access completes, `stall_m` = 0 and the FSM returns to IDLE.
    - Else if the counter = `DMEM_TIMEOUT` - 1, the access aborts: `dmem_err` pulses, `stall_m` = 0, the FSM returns to IDLE, and the instruction passes to W with `RegWriteW` forced to 0.
- `dmem_we`, `dmem_addr` (= `ALUResultM`) and `dmem_wdata` (= `WriteDataM`) are driven from the EX/MEM register, so they are stable for the whole time `dmem_req` is high.
- `dmem_ready` is ignored while `dmem_req` = 0.
- MEM/WB register: when `stall_m` = 0, it captures M contents, with `ReadDataW` = `dmem_rdata` sampled on the completing edge. When `stall_m` = 1, it loads a bubble (all control = 0, data unchanged).
- If `dmem_ready` arrives on the same cycle as the timeout, `dmem_ready` wins and the access completes normally.
- A store completes with `RegWriteW` = 0. Writes to x0 are passed through unchanged; the register file ignores them.

## Timing
- Reset (asynchronous, immediate): all outputs and registers are 0, the FSM is in IDLE, and the counter is 0. `dmem_req` and `stall_m` drop in the same cycle, including when reset is asserted mid-WAIT.
- Latency: E→M is 1 edge. M→W is 1 edge for a zero-wait access, or 1 + N edges for N wait cycles.
- `stall_m`, `dmem_req` and `dmem_err` are combinational from the FSM state, the EX/MEM register and `dmem_ready`. All W outputs are registered.
- At most one access is outstanding. A new request is issued no earlier than the cycle after completion.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - When `mem_op` = 1 and `ALUResultM[1:0]` ≠ 0, there is no request. Output `misalign_m` pulses for one cycle, there is no stall, and the instruction passes to W with `RegWriteW` = 0.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - The `misalign_m` port is absent.
  - `dmem_addr[1:0]` is forced to 0 and accesses are always word-aligned.

## Structure
- Shared package `riscv_pkg`:
  - FSM state enum `mem_state_t` (IDLE, WAIT).
  - Constants `RESULT_ALU` = 0 and `RESULT_MEM` = 1.
- One sub-module, `dmem_access_fsm`: the state register, the wait counter, and the `dmem_req`/`stall_m`/`dmem_err` logic. The pipeline registers stay in `memory_stage`.

## Test plan
- ALU op `RegWriteE` = 1, `RdE` = 5, `ALUResultE` = 0x1234 → no `dmem_req`; two edges later `RegWriteW` = 1, `RdW` = 5, `ALUResultW` = 0x1234.
- `lw` at 0x100 with `dmem_ready` = 1 immediately and `dmem_rdata` = 0xDEADBEEF → `stall_m` never high; next edge `ReadDataW` = 0xDEADBEEF and `ResultSrcW` = 1.
- `sw` at 0x104 with data 0xA5A5A5A5 and `dmem_ready` after 3 cycles → `dmem_we` = 1 and `stall_m` = 1 for 3 cycles; EX/MEM holds; W sees 3 bubbles and then a store with `RegWriteW` = 0.
- `lw` with `dmem_ready` never asserted and `DMEM_TIMEOUT` = 4 → `stall_m` = 1 for 4 cycles; `dmem_err` pulses on the 5th cycle; `RegWriteW` = 0.
- `rst_n` low during WAIT → `dmem_req`, `stall_m` and all W outputs drop to 0 at once; after release the FSM is in IDLE and the next `lw` behaves as in the zero-wait case.
- With `MEM_MISALIGN_TRAP_EN`: `lw` at 0x102 → no `dmem_req`; `misalign_m` pulses; `RegWriteW` = 0.
